// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the write-back value, commits it to the 32x32 register file,
// and serves the two ID read ports. Define WB_BYPASS_EN to get same-cycle write-through on reads.
module wb_regfile_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              RegWrite_WB,
    input  logic              MemtoReg_WB,
    input  logic [DATA_W-1:0] ReadMem_WB,
    input  logic [DATA_W-1:0] ALUResult_WB,
    input  logic [ADDR_W-1:0] WriteReg_WB,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData_WB,
    output logic              WriteValid_WB,
    output logic [CNT_W-1:0]  RetireCount
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [CNT_W-1:0]  r_retire;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wvalid;
    logic [DATA_W-1:0] w_arr_rd1;
    logic [DATA_W-1:0] w_arr_rd2;

    always_comb begin
        w_wdata  = MemtoReg_WB ? ReadMem_WB : ALUResult_WB;
        w_wvalid = RegWrite_WB && (WriteReg_WB != '0);
    end

    // Entry 0 is never written, so guarding the read keeps r0 at zero regardless of array contents.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_regs   <= '{default: '0};
            r_retire <= '0;
        end else if (w_wvalid) begin
            r_regs[WriteReg_WB] <= w_wdata;
            r_retire            <= r_retire + CNT_W'(1);
        end
    end

    always_comb begin
        w_arr_rd1 = (ReadReg1 == '0) ? '0 : r_regs[ReadReg1];
        w_arr_rd2 = (ReadReg2 == '0) ? '0 : r_regs[ReadReg2];
    end

`ifdef WB_BYPASS_EN
    // Write-through: a read of the register being committed sees the new value this cycle.
    always_comb begin
        ReadData1 = w_arr_rd1;
        ReadData2 = w_arr_rd2;
        if (w_wvalid && (ReadReg1 == WriteReg_WB)) ReadData1 = w_wdata;
        if (w_wvalid && (ReadReg2 == WriteReg_WB)) ReadData2 = w_wdata;
    end
`else
    always_comb begin
        ReadData1 = w_arr_rd1;
        ReadData2 = w_arr_rd2;
    end
`endif

    assign WriteData_WB  = w_wdata;
    assign WriteValid_WB = w_wvalid;
    assign RetireCount   = r_retire;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage; a second instance with a 4-bit
// retire counter shares all inputs so counter wrap can be observed.
module tb_wb_regfile_stage;

    logic        Clk;
    logic        Rst_n;
    logic        RegWrite_WB;
    logic        MemtoReg_WB;
    logic [31:0] ReadMem_WB;
    logic [31:0] ALUResult_WB;
    logic [4:0]  WriteReg_WB;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1, ReadData2, WriteData_WB;
    logic        WriteValid_WB;
    logic [31:0] RetireCount;
    logic [31:0] n_rd1, n_rd2, n_wdata;
    logic        n_wvalid;
    logic [3:0]  n_retire;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_collide;

    wb_regfile_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
        .ReadMem_WB(ReadMem_WB), .ALUResult_WB(ALUResult_WB), .WriteReg_WB(WriteReg_WB),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteData_WB(WriteData_WB), .WriteValid_WB(WriteValid_WB), .RetireCount(RetireCount)
    );

    wb_regfile_stage #(.CNT_W(4)) dut_w4 (
        .Clk(Clk), .Rst_n(Rst_n), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
        .ReadMem_WB(ReadMem_WB), .ALUResult_WB(ALUResult_WB), .WriteReg_WB(WriteReg_WB),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(n_rd1), .ReadData2(n_rd2),
        .WriteData_WB(n_wdata), .WriteValid_WB(n_wvalid), .RetireCount(n_retire)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic commit(input logic [4:0] idx, input logic [31:0] val);
        RegWrite_WB  = 1'b1;
        MemtoReg_WB  = 1'b0;
        WriteReg_WB  = idx;
        ALUResult_WB = val;
        step(1);
        RegWrite_WB  = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; RegWrite_WB = 1'b0; MemtoReg_WB = 1'b0;
        ReadMem_WB = '0; ALUResult_WB = '0; WriteReg_WB = '0;
        ReadReg1 = '0; ReadReg2 = '0;
        step(2);
        Rst_n = 1'b1;
        ReadReg1 = 5'd5;
        #1;
        chk("rst_rd_r5", ReadData1, 32'h0);
        chk("rst_cnt", RetireCount, 32'd0);

        // Reset with a commit pending in the same cycles
        commit(5'd5, 32'h1234);
        #1;
        chk("pre_rst_r5", ReadData1, 32'h1234);
        chk("pre_rst_cnt", RetireCount, 32'd1);
        Rst_n = 1'b0;
        RegWrite_WB = 1'b1; WriteReg_WB = 5'd5; ALUResult_WB = 32'h5555;
        #1;
        chk("rst_wvalid_comb", {31'b0, WriteValid_WB}, 32'd1);
        step(2);
        Rst_n = 1'b1; RegWrite_WB = 1'b0;
        #1;
        chk("rst_drop_r5", ReadData1, 32'h0);
        chk("rst_cnt2", RetireCount, 32'd0);

        // Write-back mux select
        RegWrite_WB = 1'b1; MemtoReg_WB = 1'b1; ReadMem_WB = 32'hDEADBEEF;
        ALUResult_WB = 32'h11; WriteReg_WB = 5'd8;
        #1;
        chk("mux_mem_comb", WriteData_WB, 32'hDEADBEEF);
        step(1);
        RegWrite_WB = 1'b0; ReadReg1 = 5'd8;
        #1;
        chk("mux_mem_r8", ReadData1, 32'hDEADBEEF);
        RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0;
        #1;
        chk("mux_alu_comb", WriteData_WB, 32'h11);
        step(1);
        RegWrite_WB = 1'b0;
        #1;
        chk("mux_alu_r8", ReadData1, 32'h11);
        chk("mux_cnt", RetireCount, 32'd2);

        // Zero register
        RegWrite_WB = 1'b1; WriteReg_WB = 5'd0; ALUResult_WB = 32'hFFFFFFFF; ReadReg2 = 5'd0;
        #1;
        chk("r0_wvalid", {31'b0, WriteValid_WB}, 32'd0);
        chk("r0_rd_pre", ReadData2, 32'h0);
        step(1);
        RegWrite_WB = 1'b0;
        #1;
        chk("r0_rd_post", ReadData2, 32'h0);
        chk("r0_cnt", RetireCount, 32'd2);

        // Read/write collision on r9
        commit(5'd9, 32'hA);
        RegWrite_WB = 1'b1; WriteReg_WB = 5'd9; ALUResult_WB = 32'hB; MemtoReg_WB = 1'b0;
        ReadReg1 = 5'd9; ReadReg2 = 5'd9;
`ifdef WB_BYPASS_EN
        exp_collide = 32'hB;
`else
        exp_collide = 32'hA;
`endif
        #1;
        chk("coll_rd1_pre", ReadData1, exp_collide);
        chk("coll_rd2_pre", ReadData2, exp_collide);
        step(1);
        RegWrite_WB = 1'b0;
        #1;
        chk("coll_rd1_post", ReadData1, 32'hB);
        chk("coll_rd2_post", ReadData2, 32'hB);
        chk("coll_cnt", RetireCount, 32'd4);

        // Disabled commit held for 10 edges
        commit(5'd3, 32'h33);
        RegWrite_WB = 1'b0; WriteReg_WB = 5'd3; ALUResult_WB = 32'h77; ReadReg1 = 5'd3;
        step(10);
        chk("nowr_r3", ReadData1, 32'h33);
        chk("nowr_cnt", RetireCount, 32'd5);

        // Counter wrap on the 4-bit instance
        Rst_n = 1'b0;
        step(1);
        Rst_n = 1'b1;
        for (int unsigned k = 0; k < 17; k++) commit(5'(k + 1), 32'h100 + k);
        #1;
        chk("wrap_cnt4", {28'b0, n_retire}, 32'd1);
        chk("wrap_cnt32", RetireCount, 32'd17);
        ReadReg1 = 5'd17; ReadReg2 = 5'd1;
        #1;
        chk("wrap_r17", ReadData1, 32'h110);
        chk("wrap_r1", ReadData2, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
